// File: rtl/ntt_pkg.sv
// Shared types and modular arithmetic helpers for the SDF NTT stage.
// Helpers work on 64-bit words; callers size results back to W.
package ntt_pkg;

    typedef logic [63:0] word_t;

    typedef enum logic {
        PH_LOAD,
        PH_BFLY
    } phase_e;

    function automatic word_t mod_add(word_t a, word_t b, word_t m);
        word_t s;
        s = a + b;
        return (s >= m) ? s - m : s;
    endfunction

    function automatic word_t mod_sub(word_t a, word_t b, word_t m);
        return (a >= b) ? a - b : a - b + m;
    endfunction

    function automatic word_t mod_mul(word_t a, word_t b, word_t m);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return word_t'(p % {64'd0, m});
    endfunction

    // OMEGA^j mod m, evaluated at elaboration for the twiddle ROM
    function automatic word_t tw_rom(word_t omega, word_t m, int j);
        word_t t;
        t = 64'd1;
        for (int i = 0; i < j; i++) t = mod_mul(t, omega, m);
        return t;
    endfunction

endpackage

// File: rtl/ntt_sdf_stage_if.sv
// Streaming bus of one SDF NTT stage.
// Master drives samples and flush; slave returns results and error.
interface ntt_sdf_stage_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         flush;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_first;
    logic         err;

    modport master (
        output in_valid, in_data, flush,
        input  out_valid, out_data, out_first, err
    );

    modport slave (
        input  in_valid, in_data, flush,
        output out_valid, out_data, out_first, err
    );
endinterface

// File: rtl/ntt_delay_line.sv
// Circular feedback buffer of an SDF stage.
// Combinational read returns the old word when read and write share an address.
module ntt_delay_line #(
    parameter int W     = 32,
    parameter int DELAY = 2,
    localparam int AW   = (DELAY > 1) ? $clog2(DELAY) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    if (DELAY == 1) begin : g_reg
        logic [W-1:0] r;
        logic [AW-1:0] unused_addr;
        assign unused_addr = addr;
        assign rdata = r;
        always_ff @(posedge clk) begin
            if (we) r <= wdata;
        end
    end else begin : g_mem
        logic [W-1:0] mem [DELAY];
        assign rdata = mem[addr];
        always_ff @(posedge clk) begin
            if (we) mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/ntt_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback NTT stage.
// One butterfly, one feedback delay line and one registered modular multiplier.
module ntt_sdf_stage
    import ntt_pkg::*;
#(
    parameter int W       = 32,
    parameter int MODULUS = 7681,
    parameter int DELAY   = 2,
    parameter int OMEGA   = 3383
) (
    input  logic            clk,
    input  logic            rst,
    ntt_sdf_stage_if.slave  bus
);

    localparam int N  = 2 * DELAY;
    localparam int KW = $clog2(N);
    localparam int AW = (DELAY > 1) ? $clog2(DELAY) : 1;

    localparam logic [W-1:0]  M      = W'(MODULUS);
    localparam logic [KW-1:0] K_HALF = KW'(DELAY);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [KW-1:0] K_DEND = KW'(DELAY - 1);

    logic [KW-1:0] k;
    logic          pending;
    logic          draining;
    logic          advance;
    phase_e        ph;
    logic [AW-1:0] addr;
    logic [W-1:0]  head;
    logic [W-1:0]  sum;
    logic [W-1:0]  diff;
    logic [W-1:0]  tw_k;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  prod;
    logic [W-1:0]  wdata;
    logic          we;

    assign advance = (bus.in_valid & ~draining) | draining;
    assign ph      = (k >= K_HALF) ? PH_BFLY : PH_LOAD;

    if (DELAY == 1) begin : g_one
        assign addr = 1'b0;
        assign tw_k = W'(1);
    end else begin : g_many
        logic [W-1:0] tw [DELAY];
        for (genvar j = 0; j < DELAY; j++) begin : g_tw
            assign tw[j] = W'(tw_rom(word_t'(OMEGA), word_t'(MODULUS), j));
        end
        assign addr = k[AW-1:0];
        assign tw_k = tw[addr];
    end

    ntt_delay_line #(
        .W     (W),
        .DELAY (DELAY)
    ) u_dl (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (head)
    );

    assign sum  = W'(mod_add(word_t'(head), word_t'(bus.in_data), word_t'(MODULUS)));
    assign diff = W'(mod_sub(word_t'(head), word_t'(bus.in_data), word_t'(MODULUS)));

    // Sums pass through the multiplier with a unit twiddle
    assign mul_a = (ph == PH_BFLY) ? sum : head;
    assign mul_b = (ph == PH_BFLY) ? W'(1) : tw_k;
    assign prod  = W'(mod_mul(word_t'(mul_a), word_t'(mul_b), word_t'(MODULUS)));

    assign we    = advance & ~draining;
    assign wdata = (ph == PH_BFLY) ? diff : bus.in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            k             <= '0;
            pending       <= 1'b0;
            draining      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_first <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
            if (bus.in_valid && (draining || bus.in_data >= M)) bus.err <= 1'b1;
            if (!draining && bus.flush && k == '0 && pending && !bus.in_valid)
                draining <= 1'b1;
            if (advance) begin
                if (ph == PH_BFLY || pending) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= prod;
                end
                bus.out_first <= (k == K_HALF);
                if (draining && k == K_DEND) begin
                    k        <= '0;
                    draining <= 1'b0;
                    pending  <= 1'b0;
                end else begin
                    k <= (k == K_LAST) ? '0 : k + 1'b1;
                    if (k == K_LAST) pending <= 1'b1;
                end
            end
        end
    end

endmodule
